// File: rtl/voice_pkg.sv
// Shared types and constants for the voice allocator and its voice slots.
package voice_pkg;

  localparam int NOTE_W = 7;
  localparam int VEL_W  = 7;

  // Allocator FSM: accept an event, scan every voice once, then commit.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  // Saturation value of a w-bit age counter (all ones).
  function automatic int unsigned age_sat(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/voice_slot.sv
// One VCO voice: holds note, velocity, gate and a saturating age counter.
// All changes are driven by single-cycle strobes from the allocator FSM;
// trig and rel are registered so they appear the cycle after the strobe.
module voice_slot
  import voice_pkg::*;
#(
  parameter int AGE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_write,
  input  logic [NOTE_W-1:0] i_note,
  input  logic [VEL_W-1:0]  i_vel,
  input  logic              i_gate_set,
  input  logic              i_gate_clr,
  input  logic              i_trig,
  input  logic              i_rel,
  input  logic              i_age_clr,
  input  logic              i_age_inc,
  output logic [NOTE_W-1:0] o_note,
  output logic [VEL_W-1:0]  o_vel,
  output logic              o_gate,
  output logic [AGE_W-1:0]  o_age,
  output logic              o_trig,
  output logic              o_rel
);

  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(age_sat(AGE_W));

  logic [NOTE_W-1:0] r_note;
  logic [VEL_W-1:0]  r_vel;
  logic              r_gate;
  logic [AGE_W-1:0]  r_age;
  logic              r_trig;
  logic              r_rel;

  // Voice state and output pulses; every register is cleared by reset so
  // the VCO inputs read zero while the allocator is held in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_note <= '0;
      r_vel  <= '0;
      r_gate <= 1'b0;
      r_age  <= '0;
      r_trig <= 1'b0;
      r_rel  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, so ordering inside this block cannot matter.
      r_trig <= i_trig;
      r_rel  <= i_rel;
      if (i_write) begin
        r_note <= i_note;
        r_vel  <= i_vel;
      end
      if (i_gate_set) begin
        r_gate <= 1'b1;
      end else if (i_gate_clr) begin
        r_gate <= 1'b0;
      end
      if (i_age_clr) begin
        r_age <= '0;
      end else if (i_age_inc && (r_age != AGE_MAX)) begin
        r_age <= r_age + 1'b1;
      end
    end
  end

  assign o_note = r_note;
  assign o_vel  = r_vel;
  assign o_gate = r_gate;
  assign o_age  = r_age;
  assign o_trig = r_trig;
  assign o_rel  = r_rel;

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: assigns MIDI note events to NUM_VOICES VCO
// slots. Each event is scanned one voice per cycle to find a retrigger
// match, the lowest free voice and the oldest held voice, then committed.
// Optional build macro VOICE_STEAL_EN: when defined, a note-on with no
// match and no free voice steals the oldest voice; otherwise it is dropped.
module voice_allocator
  import voice_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int AGE_W      = 8
) (
  input  logic                         clk_top,
  input  logic                         rst_top,
  input  logic                         ev_valid,
  output logic                         ev_ready,
  input  logic                         ev_on,
  input  logic [NOTE_W-1:0]            ev_note,
  input  logic [VEL_W-1:0]             ev_vel,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic [NUM_VOICES*VEL_W-1:0]  voice_vel,
  output logic [NUM_VOICES-1:0]        voice_gate,
  output logic [NUM_VOICES-1:0]        voice_trig,
  output logic [NUM_VOICES-1:0]        voice_rel,
  output logic                         drop,
  output logic                         busy
);

  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  // FSM and latched event
  state_t            r_state;
  state_t            w_state_next;
  logic              r_alive;
  logic [IDX_W-1:0]  r_idx;
  logic              r_on;
  logic [NOTE_W-1:0] r_note;
  logic [VEL_W-1:0]  r_vel;
  logic              r_drop;
  logic              w_accept;

  // Scan candidates
  logic              r_match_vld;
  logic [IDX_W-1:0]  r_match_idx;
  logic              r_free_vld;
  logic [IDX_W-1:0]  r_free_idx;
  logic              r_old_vld;
  logic [IDX_W-1:0]  r_old_idx;
  logic [AGE_W-1:0]  r_old_age;

  // Commit decode
  logic              w_do_on;
  logic              w_do_off;
  logic              w_drop_nxt;
  logic [IDX_W-1:0]  w_tgt;

  // Slot interface
  logic [NOTE_W-1:0]     w_note [NUM_VOICES];
  logic [VEL_W-1:0]      w_vel  [NUM_VOICES];
  logic [AGE_W-1:0]      w_age  [NUM_VOICES];
  logic [NUM_VOICES-1:0] w_gate;
  logic [NUM_VOICES-1:0] w_trig_q;
  logic [NUM_VOICES-1:0] w_rel_q;
  logic [NUM_VOICES-1:0] w_write;
  logic [NUM_VOICES-1:0] w_gate_set;
  logic [NUM_VOICES-1:0] w_gate_clr;
  logic [NUM_VOICES-1:0] w_trig;
  logic [NUM_VOICES-1:0] w_rel;
  logic [NUM_VOICES-1:0] w_age_clr;
  logic [NUM_VOICES-1:0] w_age_inc;

  // State register; r_alive holds ev_ready low until the first clock
  // after reset release.
  always_ff @(posedge clk_top or negedge rst_top) begin
    if (!rst_top) begin
      r_state <= S_IDLE;
      r_alive <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_alive <= 1'b1;
    end
  end

  // Next-state logic: IDLE -> SCAN (one voice per cycle) -> COMMIT -> IDLE.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    w_state_next = r_state;
    w_accept     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (ev_valid && r_alive) begin
          w_accept     = 1'b1;
          w_state_next = S_SCAN;
        end
      end
      S_SCAN: begin
        if (r_idx == LAST_IDX) begin
          w_state_next = S_COMMIT;
        end
      end
      S_COMMIT: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  assign ev_ready = r_alive && (r_state == S_IDLE);
  assign busy     = (r_state != S_IDLE);

  // Event latch and candidate search; velocity 0 on a note-on is a note-off.
  always_ff @(posedge clk_top or negedge rst_top) begin
    if (!rst_top) begin
      r_idx       <= '0;
      r_on        <= 1'b0;
      r_note      <= '0;
      r_vel       <= '0;
      r_match_vld <= 1'b0;
      r_match_idx <= '0;
      r_free_vld  <= 1'b0;
      r_free_idx  <= '0;
      r_old_vld   <= 1'b0;
      r_old_idx   <= '0;
      r_old_age   <= '0;
    end else if (w_accept) begin
      r_idx       <= '0;
      r_on        <= ev_on && (ev_vel != '0);
      r_note      <= ev_note;
      r_vel       <= ev_vel;
      r_match_vld <= 1'b0;
      r_free_vld  <= 1'b0;
      r_old_vld   <= 1'b0;
    end else if (r_state == S_SCAN) begin
      r_idx <= r_idx + 1'b1;
      if (w_gate[r_idx]) begin
        if (!r_match_vld && (w_note[r_idx] == r_note)) begin
          r_match_vld <= 1'b1;
          r_match_idx <= r_idx;
        end
        // Strict compare keeps the lowest index on equal ages.
        if (!r_old_vld || (w_age[r_idx] > r_old_age)) begin
          r_old_vld <= 1'b1;
          r_old_idx <= r_idx;
          r_old_age <= w_age[r_idx];
        end
      end else if (!r_free_vld) begin
        r_free_vld <= 1'b1;
        r_free_idx <= r_idx;
      end
    end
  end

  // Commit decision: pick the target voice, or flag a drop.
  always_comb begin
    w_do_on    = 1'b0;
    w_do_off   = 1'b0;
    w_drop_nxt = 1'b0;
    w_tgt      = '0;
    if (r_state == S_COMMIT) begin
      if (r_on) begin
        if (r_match_vld) begin
          w_do_on = 1'b1;
          w_tgt   = r_match_idx;
        end else if (r_free_vld) begin
          w_do_on = 1'b1;
          w_tgt   = r_free_idx;
        end
`ifdef VOICE_STEAL_EN
        else if (r_old_vld) begin
          w_do_on = 1'b1;
          w_tgt   = r_old_idx;
        end else begin
          w_drop_nxt = 1'b1;
        end
`else
        else begin
          w_drop_nxt = 1'b1;
        end
`endif
      end else if (r_match_vld) begin
        w_do_off = 1'b1;
        w_tgt    = r_match_idx;
      end
    end
  end

  // Per-voice strobes derived from the commit decision.
  always_comb begin
    w_write    = '0;
    w_gate_set = '0;
    w_gate_clr = '0;
    w_trig     = '0;
    w_rel      = '0;
    w_age_clr  = '0;
    w_age_inc  = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (w_tgt == IDX_W'(i)) begin
        w_write[i]    = w_do_on;
        w_gate_set[i] = w_do_on;
        w_trig[i]     = w_do_on;
        w_gate_clr[i] = w_do_off;
        w_rel[i]      = w_do_off;
        w_age_clr[i]  = w_do_on || w_do_off;
      end else begin
        w_age_inc[i]  = w_do_on && w_gate[i];
      end
    end
  end

  // Drop pulse, high for the cycle after COMMIT.
  always_ff @(posedge clk_top or negedge rst_top) begin
    if (!rst_top) begin
      r_drop <= 1'b0;
    end else begin
      r_drop <= w_drop_nxt;
    end
  end

  assign drop = r_drop;

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_slot
    voice_slot #(
      .AGE_W (AGE_W)
    ) u_slot (
      .clk        (clk_top),
      .rst_n      (rst_top),
      .i_write    (w_write[g]),
      .i_note     (r_note),
      .i_vel      (r_vel),
      .i_gate_set (w_gate_set[g]),
      .i_gate_clr (w_gate_clr[g]),
      .i_trig     (w_trig[g]),
      .i_rel      (w_rel[g]),
      .i_age_clr  (w_age_clr[g]),
      .i_age_inc  (w_age_inc[g]),
      .o_note     (w_note[g]),
      .o_vel      (w_vel[g]),
      .o_gate     (w_gate[g]),
      .o_age      (w_age[g]),
      .o_trig     (w_trig_q[g]),
      .o_rel      (w_rel_q[g])
    );
  end

  // Pack per-voice note and velocity onto the flat output buses.
  always_comb begin
    voice_note = '0;
    voice_vel  = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      voice_note[i*NOTE_W +: NOTE_W] = w_note[i];
      voice_vel[i*VEL_W +: VEL_W]    = w_vel[i];
    end
  end

  assign voice_gate = w_gate;
  assign voice_trig = w_trig_q;
  assign voice_rel  = w_rel_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator (NUM_VOICES = 4, AGE_W = 8). A behavioural
// model of the allocation rules runs alongside; a negedge process compares
// every output against it each cycle, and directed steps pin literal values.
// Honours VOICE_STEAL_EN the same way the design does.
module tb_voice_allocator;

  localparam int NV      = 4;
  localparam int AGE_MAX = 255;

  logic            clk_top = 1'b0;
  logic            rst_top = 1'b0;
  logic            ev_valid = 1'b0;
  logic            ev_on = 1'b0;
  logic [6:0]      ev_note = '0;
  logic [6:0]      ev_vel = '0;
  logic            ev_ready;
  logic [NV*7-1:0] voice_note;
  logic [NV*7-1:0] voice_vel;
  logic [NV-1:0]   voice_gate;
  logic [NV-1:0]   voice_trig;
  logic [NV-1:0]   voice_rel;
  logic            drop;
  logic            busy;

  voice_allocator #(.NUM_VOICES(NV), .AGE_W(8)) u_dut (
    .clk_top    (clk_top),
    .rst_top    (rst_top),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_on      (ev_on),
    .ev_note    (ev_note),
    .ev_vel     (ev_vel),
    .voice_note (voice_note),
    .voice_vel  (voice_vel),
    .voice_gate (voice_gate),
    .voice_trig (voice_trig),
    .voice_rel  (voice_rel),
    .drop       (drop),
    .busy       (busy)
  );

  always #5 clk_top = ~clk_top;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  int          m_note [NV];
  int          m_vel  [NV];
  int          m_age  [NV];
  bit          m_gate [NV];
  logic [NV-1:0] m_trig = '0;
  logic [NV-1:0] m_rel  = '0;
  logic        m_drop  = 1'b0;
  logic        m_ready = 1'b0;
  logic        m_busy  = 1'b0;

  // Pulses observed in the cycle after COMMIT
  logic [NV-1:0] p_trig;
  logic [NV-1:0] p_rel;
  logic          p_drop;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_note[i] = 0; m_vel[i] = 0; m_age[i] = 0; m_gate[i] = 0;
    end
    m_trig = '0; m_rel = '0; m_drop = 1'b0; m_ready = 1'b0; m_busy = 1'b0;
  endtask

  // Allocation rules applied to one whole event.
  task automatic model_apply(input bit on, input int note, input int vel);
    bit eff_on;
    int mi, fi, oi, tgt;
    eff_on = on && (vel != 0);
    mi = -1; fi = -1; oi = -1;
    for (int i = 0; i < NV; i++) begin
      if (m_gate[i] && m_note[i] == note && mi < 0) mi = i;
      if (!m_gate[i] && fi < 0) fi = i;
      if (m_gate[i] && (oi < 0 || m_age[i] > m_age[oi])) oi = i;
    end
    if (eff_on) begin
      tgt = (mi >= 0) ? mi : (fi >= 0) ? fi : -1;
`ifdef VOICE_STEAL_EN
      if (tgt < 0) tgt = oi;
`endif
      if (tgt < 0) begin
        m_drop = 1'b1;
      end else begin
        for (int i = 0; i < NV; i++)
          if (i != tgt && m_gate[i] && m_age[i] < AGE_MAX) m_age[i]++;
        m_note[tgt] = note; m_vel[tgt] = vel; m_gate[tgt] = 1;
        m_age[tgt] = 0; m_trig[tgt] = 1'b1;
      end
    end else if (mi >= 0) begin
      m_gate[mi] = 0; m_rel[mi] = 1'b1; m_age[mi] = 0;
    end
  endtask

  function automatic logic [NV*7-1:0] pack7(input int v [NV]);
    logic [NV*7-1:0] r;
    r = '0;
    for (int i = 0; i < NV; i++) r[i*7 +: 7] = v[i][6:0];
    return r;
  endfunction

  function automatic logic [NV-1:0] gate_vec();
    logic [NV-1:0] r;
    for (int i = 0; i < NV; i++) r[i] = m_gate[i];
    return r;
  endfunction

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk_top) begin
    check("ev_ready", 64'(ev_ready), 64'(m_ready));
    check("busy", 64'(busy), 64'(m_busy));
    check("voice_gate", 64'(voice_gate), 64'(gate_vec()));
    check("voice_trig", 64'(voice_trig), 64'(m_trig));
    check("voice_rel", 64'(voice_rel), 64'(m_rel));
    check("drop", 64'(drop), 64'(m_drop));
    check("voice_note", 64'(voice_note), 64'(pack7(m_note)));
    check("voice_vel", 64'(voice_vel), 64'(pack7(m_vel)));
  end

  // Drive one event through accept, N scan cycles, commit and pulse cycle.
  task automatic send(input bit on, input int note, input int vel, input bit hold);
    @(posedge clk_top); #1;
    ev_valid = 1'b1; ev_on = on; ev_note = 7'(note); ev_vel = 7'(vel);
    @(posedge clk_top);                      // accept edge (end of cycle 0)
    m_ready = 1'b0; m_busy = 1'b1; m_trig = '0; m_rel = '0; m_drop = 1'b0;
    #1;
    if (hold) ev_note = ev_note ^ 7'h15;     // stays valid with a new note
    else ev_valid = 1'b0;
    repeat (NV) @(posedge clk_top);          // scan cycles 1..N
    #1 ev_valid = 1'b0;
    @(posedge clk_top);                      // end of COMMIT
    model_apply(on, note, vel);
    m_ready = 1'b1; m_busy = 1'b0;
    @(negedge clk_top);
    p_trig = voice_trig; p_rel = voice_rel; p_drop = drop;
    @(posedge clk_top);
    m_trig = '0; m_rel = '0; m_drop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk_top);
    #1 rst_top = 1'b1;
    @(posedge clk_top);
    m_ready = 1'b1;
    @(negedge clk_top);
    check("ready_after_reset", 64'(ev_ready), 64'd1);

    // First note lands on voice 0, trig in cycle N+2 = 6
    send(1, 60, 100, 0);
    check("v0_note", 64'(voice_note[6:0]), 64'd60);
    check("v0_vel", 64'(voice_vel[6:0]), 64'd100);
    check("gate_first", 64'(voice_gate), 64'b0001);
    check("trig_first", 64'(p_trig), 64'b0001);
    check("rel_first", 64'(p_rel), 64'b0000);

    // Retrigger same note with a new velocity
    send(1, 60, 40, 0);
    check("retrig_vel", 64'(voice_vel[6:0]), 64'd40);
    check("retrig_gate", 64'(voice_gate), 64'b0001);
    check("retrig_trig", 64'(p_trig), 64'b0001);

    // Fill voices 1 and 2; pin model ages
    send(1, 62, 80, 0);
    send(1, 64, 90, 0);
    check("gate_three", 64'(voice_gate), 64'b0111);
    check("model_age0", 64'(m_age[0]), 64'd2);
    check("model_age1", 64'(m_age[1]), 64'd1);
    check("model_age2", 64'(m_age[2]), 64'd0);

    send(1, 66, 70, 0);
    check("trig_fourth", 64'(p_trig), 64'b1000);
    check("gate_full", 64'(voice_gate), 64'b1111);

    // Fifth note: steal the oldest (voice 0) or drop
    send(1, 67, 50, 0);
`ifdef VOICE_STEAL_EN
    check("steal_trig", 64'(p_trig), 64'b0001);
    check("steal_rel", 64'(p_rel), 64'b0000);
    check("steal_note", 64'(voice_note[6:0]), 64'd67);
    check("steal_drop", 64'(p_drop), 64'd0);
`else
    check("drop_pulse", 64'(p_drop), 64'd1);
    check("drop_note", 64'(voice_note[6:0]), 64'd60);
    check("drop_trig", 64'(p_trig), 64'b0000);
`endif

    // Note-off of a held note, then of an absent note
    send(0, 62, 64, 0);
    check("off_rel", 64'(p_rel), 64'b0010);
    check("off_gate", 64'(voice_gate), 64'b1101);
    check("off_note_held", 64'(voice_note[13:7]), 64'd62);
    send(0, 70, 64, 0);
    check("off_miss_rel", 64'(p_rel), 64'b0000);
    check("off_miss_drop", 64'(p_drop), 64'd0);

    // Velocity 0 note-on releases voice 2
    send(1, 64, 0, 0);
    check("vel0_rel", 64'(p_rel), 64'b0100);
    check("vel0_trig", 64'(p_trig), 64'b0000);

    // ev_valid held through the scan: one event only, lands on free voice 1
    send(1, 70, 10, 1);
    check("hold_trig", 64'(p_trig), 64'b0010);
    check("hold_note", 64'(voice_note[13:7]), 64'd70);

    // Reset asserted mid-scan aborts the event
    @(posedge clk_top); #1;
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd71; ev_vel = 7'd20;
    @(posedge clk_top);
    m_ready = 1'b0; m_busy = 1'b1;
    #1 ev_valid = 1'b0;
    @(posedge clk_top); #1;
    rst_top = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_top);
    #1 rst_top = 1'b1;
    @(posedge clk_top);
    m_ready = 1'b1;
    @(negedge clk_top);
    check("rst_gate", 64'(voice_gate), 64'd0);
    check("rst_ready", 64'(ev_ready), 64'd1);
    check("rst_notes", 64'(voice_note), 64'd0);

    send(1, 61, 33, 0);
    check("post_rst_trig", 64'(p_trig), 64'b0001);
    check("post_rst_note", 64'(voice_note[6:0]), 64'd61);

    repeat (2) @(posedge clk_top);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Polyphonic voice scheduler ahead of the VCO voice instances: accepts MIDI note events and assigns each to one of NUM_VOICES VCO slots.
- Drives each VCO's note_freq, velocity, note_on and note_off inputs.
- Resolves retrigger of the same note, free-voice selection and oldest-voice stealing with a sequential scan, one voice per cycle.

Parameters:
- NUM_VOICES, 4, number of VCO voices managed (2..16).
- AGE_W, 8, width of per-voice saturating age counter.

Ports:
- clk_top  in  1  system clock.
- rst_top  in  1  reset; asynchronous, active-low.
- ev_valid  in  1  event present.
- ev_ready  out  1  allocator can accept an event.
- ev_on  in  1  1 = note on, 0 = note off.
- ev_note  in  7  MIDI note number.
- ev_vel  in  7  MIDI velocity.
- voice_note  out  NUM_VOICES*7  per-voice note; voice i at bits [7i+6:7i].
- voice_vel  out  NUM_VOICES*7  per-voice velocity, same packing.
- voice_gate  out  NUM_VOICES  voice held.
- voice_trig  out  NUM_VOICES  one-cycle note_on pulse per voice.
- voice_rel  out  NUM_VOICES  one-cycle note_off pulse per voice.
- drop  out  1  one-cycle pulse: note-on discarded.
- busy  out  1  FSM not IDLE.

Behaviour:
- Reset (rst_top = 0): all outputs 0, all ages 0, FSM in IDLE. ev_ready is 0 during reset and 1 in the first cycle after release. Reset mid-scan aborts the pending event with no output change.
- FSM states: IDLE -> SCAN -> COMMIT -> IDLE.
- IDLE: ev_ready = 1. When ev_valid && ev_ready, latch ev_on, ev_note and ev_vel, clear search flags, set idx = 0 and go to SCAN. ev_ready = 0 in all other states.
- SCAN: examine one voice per cycle (idx 0..NUM_VOICES-1) and record three candidates:
  - match: lowest-index gated voice whose note equals the latched note.
  - free: lowest-index non-gated voice.
  - oldest: gated voice with the largest age; ties go to the lowest index.
  - After idx = NUM_VOICES-1, go to COMMIT.
- COMMIT, note on, priority order:
  - match: rewrite vel, pulse trig, gate stays 1.
  - else free: write note and vel, set gate, pulse trig.
  - else steal or drop, per the optional feature.
  - The target voice's age is set to 0. Every other gated voice's age increments, saturating at 2^AGE_W-1.
- COMMIT, note off:
  - match: clear gate, pulse rel, age = 0; note and vel are held.
  - No match: event ignored, no drop pulse, ages unchanged.
- Registered outputs update at the end of COMMIT. trig, rel and drop are high for exactly the cycle after COMMIT.
- Latency: accept in cycle 0, SCAN in cycles 1..N, COMMIT in cycle N+1, pulses in cycle N+2. ev_ready is back in cycle N+2. Throughput is one event per N+2 cycles.
- Velocity 0 with ev_on = 1 is treated as note off (MIDI running-status convention).
- Non-target voices never change note or vel.

Optional Feature:
- Macro: VOICE_STEAL_EN.
- Defined: a note-on with no match and no free voice takes the oldest voice. Its note and vel are replaced, gate stays 1, trig pulses, no rel pulse, and its age becomes 0.
- Undefined: the same event is discarded, drop pulses, and no voice state or age changes.

Decomposition:
- Shared package voice_pkg: NOTE_W = 7, VEL_W = 7, FSM state encoding (S_IDLE, S_SCAN, S_COMMIT) and the age saturation constant.
- One sub-module, voice_slot, instantiated NUM_VOICES times. It holds note, vel, gate and age, and takes write/trig/rel/age_clr/age_inc strobes from the FSM.

Test Plan:
- Reset, then note-on 60 vel 100 (NUM_VOICES = 4) -> voice 0 note 60, vel 100, gate = 1; trig[0] pulses in cycle 6 after accept.
- Note-on 60, 62, 64 in sequence -> voices 0, 1, 2 assigned; ages of voices 0/1/2 are 2/1/0.
- Note-on 60 vel 100, then note-on 60 vel 40 -> voice 0 retriggered with vel 40; voice 1 stays ungated.
- Five note-ons 60..64 with steal enabled -> the fifth goes to voice 0, trig[0] pulses, no rel. With steal disabled -> drop pulses and voice 0 keeps note 60.
- Note-off 62 with voices holding 60/62 -> gate[1] = 0, rel[1] pulses. Note-off 70 -> no pulse, no drop.
- ev_valid held high during SCAN -> ev_ready = 0 and no second latch. rst_top asserted mid-SCAN -> all outputs 0 and ev_ready = 1 after release.
